stage_two_execute: RTL and testbench



---
 rtl/stage_two_execute.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_stage_two_execute.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_two_execute.sv
// Stage-two execute: operand forwarding, ALU (incl. signed multiply and unsigned divide) and the
// stage-2/3 pipeline register. Define ITER_DIV_EN for the IDLE/RUN/DONE restoring divider; otherwise DIV is single-cycle.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5,
    ALU_ROL = 4'd6,
    ALU_ROR = 4'd7,
    ALU_MUL = 4'd8,
    ALU_DIV = 4'd9
  } control_e;
endpackage

module stage_two_execute
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIV_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt_sys,
  input  logic                 in_bubble,
  input  logic [WIDTH-1:0]     in_alu_a,
  input  logic [WIDTH-1:0]     in_alu_b,
  input  logic [3:0]           in_alu_ctrl,
  input  logic                 in_haz1,
  input  logic                 in_haz2,
  input  logic [WIDTH-1:0]     s3_fwd_data,
  input  logic                 in_memc,
  input  logic                 in_reg_wr,
  input  logic                 in_R0_en,
  input  logic [WIDTH-1:0]     in_R1_data,
  input  logic [15:0]          in_instr,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   out_aluout,
  output logic                 out_memc,
  output logic                 out_reg_wr,
  output logic                 out_R0_en,
  output logic [WIDTH-1:0]     out_R1_data,
  output logic [15:0]          out_instr,
  output logic                 out_ovf,
  output logic                 out_div0
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] W_LEN = (SHW + 1)'(WIDTH);

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SHW-1:0]     w_shamt;
  logic [SHW:0]       w_rshamt;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rol;
  logic [WIDTH-1:0]   w_ror;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_div_comb;
  logic [2*WIDTH-1:0] w_result;
  logic               w_ovf;
  logic               w_div0;
  logic               w_b_zero;

  logic               w_load_nop;
  logic               w_load_div;
  logic [2*WIDTH-1:0] w_div_aluout;
  logic               w_div_memc;
  logic               w_div_reg_wr;
  logic               w_div_R0_en;
  logic [WIDTH-1:0]   w_div_R1_data;
  logic [15:0]        w_div_instr;

  assign w_a      = in_haz1 ? s3_fwd_data : in_alu_a;
  assign w_b      = in_haz2 ? s3_fwd_data : in_alu_b;
  assign w_b_zero = (w_b == '0);
  assign w_shamt  = w_b[SHW-1:0];
  // a shift by the full width yields zero, which makes the zero-amount rotate fall out naturally
  assign w_rshamt = W_LEN - {1'b0, w_shamt};
  assign w_sum    = w_a + w_b;
  assign w_diff   = w_a - w_b;
  assign w_rol    = (w_a << w_shamt) | (w_a >> w_rshamt);
  assign w_ror    = (w_a >> w_shamt) | (w_a << w_rshamt);
  assign w_prod   = $signed({{WIDTH{w_a[MSB]}}, w_a}) * $signed({{WIDTH{w_b[MSB]}}, w_b});

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_div0   = 1'b0;
    case (in_alu_ctrl)
      ALU_ADD: begin
        w_result[WIDTH-1:0] = w_sum;
        w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
      ALU_SUB: begin
        w_result[WIDTH-1:0] = w_diff;
        w_ovf = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
      end
      ALU_AND: w_result[WIDTH-1:0] = w_a & w_b;
      ALU_OR:  w_result[WIDTH-1:0] = w_a | w_b;
      ALU_SLL: w_result[WIDTH-1:0] = w_a << w_shamt;
      ALU_SRL: w_result[WIDTH-1:0] = w_a >> w_shamt;
      ALU_ROL: w_result[WIDTH-1:0] = w_rol;
      ALU_ROR: w_result[WIDTH-1:0] = w_ror;
      ALU_MUL: w_result = w_prod;
      ALU_DIV: begin
        if (w_b_zero) begin
          w_result = {w_a, {WIDTH{1'b1}}};
          w_div0   = 1'b1;
        end else begin
          w_result = w_div_comb;
        end
      end
      default: w_result = '0;
    endcase
  end

`ifdef ITER_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_memc_l;
  logic             r_reg_wr_l;
  logic             r_R0_en_l;
  logic [WIDTH-1:0] r_R1_data_l;
  logic [15:0]      r_instr_l;
  logic             w_start;
  logic             w_div_start;
  logic             w_div_step;
  logic [WIDTH:0]   w_shift;
  logic             w_fit;
  logic [WIDTH-1:0] w_sub;

  assign w_div_comb = '0;
  assign w_start    = (in_alu_ctrl == ALU_DIV) && !w_b_zero && !in_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (!halt_sys) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    w_div_start  = 1'b0;
    w_div_step   = 1'b0;
    w_load_nop   = in_bubble;
    w_load_div   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          busy         = 1'b1;
          w_load_nop   = 1'b1;
          w_div_start  = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        w_load_nop = 1'b1;
        w_div_step = 1'b1;
        if (r_count == CNT_LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // the divide result must not be dropped, so DONE takes priority over a bubble
        w_load_nop   = 1'b0;
        w_load_div   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (rst) begin
      busy = 1'b0;
    end
  end

  // restoring step: shift next dividend bit into the remainder, subtract divisor if it fits
  assign w_shift = {r_rem, r_quo[MSB]};
  assign w_fit   = (w_shift >= {1'b0, r_dvsr});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_memc_l    <= 1'b0;
      r_reg_wr_l  <= 1'b0;
      r_R0_en_l   <= 1'b0;
      r_R1_data_l <= '0;
      r_instr_l   <= '0;
    end else if (!halt_sys) begin
      if (w_div_start) begin
        r_count     <= '0;
        r_rem       <= '0;
        r_quo       <= w_a;
        r_dvsr      <= w_b;
        r_memc_l    <= in_memc;
        r_reg_wr_l  <= in_reg_wr;
        r_R0_en_l   <= in_R0_en;
        r_R1_data_l <= in_R1_data;
        r_instr_l   <= in_instr;
      end else if (w_div_step) begin
        r_rem   <= w_fit ? w_sub : w_shift[WIDTH-1:0];
        r_quo   <= {r_quo[WIDTH-2:0], w_fit};
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign w_div_aluout  = {r_rem, r_quo};
  assign w_div_memc    = r_memc_l;
  assign w_div_reg_wr  = r_reg_wr_l;
  assign w_div_R0_en   = r_R0_en_l;
  assign w_div_R1_data = r_R1_data_l;
  assign w_div_instr   = r_instr_l;
`else
  logic [WIDTH-1:0] w_quo_c;
  logic [WIDTH-1:0] w_rem_c;

  assign w_quo_c       = w_a / w_b;
  assign w_rem_c       = w_a % w_b;
  assign w_div_comb    = {w_rem_c, w_quo_c};
  assign busy          = 1'b0;
  assign w_load_nop    = in_bubble;
  assign w_load_div    = 1'b0;
  assign w_div_aluout  = '0;
  assign w_div_memc    = 1'b0;
  assign w_div_reg_wr  = 1'b0;
  assign w_div_R0_en   = 1'b0;
  assign w_div_R1_data = '0;
  assign w_div_instr   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_aluout  <= '0;
      out_memc    <= 1'b0;
      out_reg_wr  <= 1'b0;
      out_R0_en   <= 1'b0;
      out_R1_data <= '0;
      out_instr   <= '0;
      out_ovf     <= 1'b0;
      out_div0    <= 1'b0;
    end else if (!halt_sys) begin
      if (w_load_div) begin
        out_aluout  <= w_div_aluout;
        out_memc    <= w_div_memc;
        out_reg_wr  <= w_div_reg_wr;
        out_R0_en   <= w_div_R0_en;
        out_R1_data <= w_div_R1_data;
        out_instr   <= w_div_instr;
        out_ovf     <= 1'b0;
        out_div0    <= 1'b0;
      end else if (w_load_nop) begin
        out_aluout  <= '0;
        out_memc    <= 1'b0;
        out_reg_wr  <= 1'b0;
        out_R0_en   <= 1'b0;
        out_R1_data <= '0;
        out_instr   <= '0;
        out_ovf     <= 1'b0;
        out_div0    <= 1'b0;
      end else begin
        out_aluout  <= w_result;
        out_memc    <= in_memc;
        out_reg_wr  <= in_reg_wr;
        out_R0_en   <= in_R0_en;
        out_R1_data <= in_R1_data;
        out_instr   <= in_instr;
        out_ovf     <= w_ovf;
        out_div0    <= w_div0;
      end
    end
  end

endmodule

// File: tb/tb_stage_two_execute.sv
// Self-checking bench for stage_two_execute: vector table, hand-written divide/reset/halt
// sequences and a randomized run against an arithmetic reference model.
module tb_stage_two_execute;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys;
  logic        in_bubble;
  logic [15:0] in_alu_a;
  logic [15:0] in_alu_b;
  logic [3:0]  in_alu_ctrl;
  logic        in_haz1;
  logic        in_haz2;
  logic [15:0] s3_fwd_data;
  logic        in_memc;
  logic        in_reg_wr;
  logic        in_R0_en;
  logic [15:0] in_R1_data;
  logic [15:0] in_instr;
  logic        busy;
  logic [31:0] out_aluout;
  logic        out_memc;
  logic        out_reg_wr;
  logic        out_R0_en;
  logic [15:0] out_R1_data;
  logic [15:0] out_instr;
  logic        out_ovf;
  logic        out_div0;

  stage_two_execute dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_bubble(in_bubble),
    .in_alu_a(in_alu_a), .in_alu_b(in_alu_b), .in_alu_ctrl(in_alu_ctrl),
    .in_haz1(in_haz1), .in_haz2(in_haz2), .s3_fwd_data(s3_fwd_data),
    .in_memc(in_memc), .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en),
    .in_R1_data(in_R1_data), .in_instr(in_instr), .busy(busy),
    .out_aluout(out_aluout), .out_memc(out_memc), .out_reg_wr(out_reg_wr),
    .out_R0_en(out_R0_en), .out_R1_data(out_R1_data), .out_instr(out_instr),
    .out_ovf(out_ovf), .out_div0(out_div0)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic        ovf;
    logic        div0;
    logic        reg_wr;
    logic        memc;
    logic        r0;
    logic [15:0] r1;
    logic [15:0] instr;
  } out_t;

  typedef struct packed {
    logic [31:0] alu;
    logic        ovf;
    logic        div0;
  } res_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        h1;
    logic        h2;
    logic [15:0] fwd;
    logic [31:0] exp_alu;
    logic        exp_ovf;
    logic        exp_div0;
  } vec_t;

  // arithmetic reference: signed/unsigned integers, no knowledge of the datapath
  function automatic res_t ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t   r;
    int     sa, sb, s, ua, ub, sh;
    longint p;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    sh = ub % 16;
    case (op)
      ALU_ADD: begin s = sa + sb; r.alu = 32'((ua + ub) & 'hFFFF); r.ovf = (s > 32767) || (s < -32768); end
      ALU_SUB: begin s = sa - sb; r.alu = 32'((ua - ub) & 'hFFFF); r.ovf = (s > 32767) || (s < -32768); end
      ALU_AND: r.alu = 32'(ua & ub);
      ALU_OR:  r.alu = 32'(ua | ub);
      ALU_SLL: r.alu = 32'((ua << sh) & 'hFFFF);
      ALU_SRL: r.alu = 32'(ua >> sh);
      ALU_ROL: r.alu = 32'(((ua << sh) | (ua >> (16 - sh))) & 'hFFFF);
      ALU_ROR: r.alu = 32'(((ua >> sh) | (ua << (16 - sh))) & 'hFFFF);
      ALU_MUL: begin p = longint'(sa) * longint'(sb); r.alu = 32'(p); end
      ALU_DIV: begin
        if (ub == 0) begin r.alu = {a, 16'hFFFF}; r.div0 = 1'b1; end
        else r.alu = 32'(((ua % ub) << 16) | (ua / ub));
      end
      default: r.alu = '0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic h1, input logic h2, input logic [15:0] fwd,
                       input logic bub, input logic hlt, input logic rw, input logic mc,
                       input logic r0, input logic [15:0] r1, input logic [15:0] ins);
    in_alu_ctrl = op;  in_alu_a = a;  in_alu_b = b;
    in_haz1 = h1;  in_haz2 = h2;  s3_fwd_data = fwd;
    in_bubble = bub;  halt_sys = hlt;
    in_reg_wr = rw;  in_memc = mc;  in_R0_en = r0;  in_R1_data = r1;  in_instr = ins;
  endtask

  task automatic check_out(input string name, input out_t exp, input logic chk_pass);
    out_t act;
    logic ok;
    act = {out_aluout, out_ovf, out_div0, out_reg_wr, out_memc, out_R0_en, out_R1_data, out_instr};
    ok = (act.alu == exp.alu) && (act.ovf == exp.ovf) && (act.div0 == exp.div0) &&
         (act.reg_wr == exp.reg_wr) && (act.memc == exp.memc) && (act.r0 == exp.r0) &&
         (!chk_pass || ((act.r1 == exp.r1) && (act.instr == exp.instr)));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got alu=%h ovf=%b div0=%b rw=%b mc=%b r0=%b r1=%h ins=%h, want alu=%h ovf=%b div0=%b rw=%b mc=%b r0=%b r1=%h ins=%h",
               name, act.alu, act.ovf, act.div0, act.reg_wr, act.memc, act.r0, act.r1, act.instr,
               exp.alu, exp.ovf, exp.div0, exp.reg_wr, exp.memc, exp.r0, exp.r1, exp.instr);
    end else begin
      $display("ok   %s alu=%h ovf=%b div0=%b", name, act.alu, act.ovf, act.div0);
    end
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      failures++;
      $display("FAIL %s: busy got %b want %b", name, busy, exp);
    end
  endtask

  function automatic out_t mk_exp(input res_t r, input logic rw, input logic mc, input logic r0,
                                  input logic [15:0] r1, input logic [15:0] ins);
    return {r.alu, r.ovf, r.div0, rw, mc, r0, r1, ins};
  endfunction

  // Starts and ends at posedge+1. Expected sideband is the one presented with the DIV.
  task automatic div_seq(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int halt_at, input int halt_len, input logic [31:0] exp_alu);
    out_t exp;
    exp = {exp_alu, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hD1D1};
    drive(ALU_DIV, a, b, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hD1D1);
`ifdef ITER_DIV_EN
    begin
      int   e;
      int   k;
      logic halted;
      e = 0;
      k = 0;
      while (e <= 17) begin
        halted = (k >= halt_at) && (k < halt_at + halt_len);
        halt_sys = halted;
        if (k == 1) begin
          in_alu_a = 16'($urandom);  in_alu_b = 16'($urandom);
          in_reg_wr = 1'b0;  in_memc = 1'b1;  in_R0_en = 1'b0;
          in_R1_data = 16'h0;  in_instr = 16'($urandom);
        end
        @(negedge clk);
        check_busy($sformatf("%s_busy%0d", name, k), e <= 16);
        @(posedge clk); #1;
        if (!halted) e++;
        k++;
        if (e == 18) check_out(name, exp, 1'b1);
        else check_out($sformatf("%s_nop%0d", name, k), '0, 1'b0);
      end
      halt_sys = 1'b0;
    end
`else
    @(negedge clk);
    check_busy({name, "_busy"}, 1'b0);
    @(posedge clk); #1;
    check_out(name, exp, 1'b1);
    if (halt_at < 0 || halt_len < 0) $display("note: halt window ignored");
`endif
    drive(ALU_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    vec_t vecs[$];
    out_t model;
    logic model_pass;

    // reset with a divide presented: everything stays zero, busy low
    drive(ALU_DIV, 16'd100, 16'd7, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", '0, 1'b1);
    @(negedge clk);
    check_busy("reset_busy", 1'b0);
    @(posedge clk); #1;
    drive(ALU_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;

    vecs.push_back('{"add_ovf",   ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0000_8000, 1'b1, 1'b0});
    vecs.push_back('{"sub_ovf",   ALU_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0000_7FFF, 1'b1, 1'b0});
    vecs.push_back('{"sub_neg",   ALU_SUB, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h0000, 32'h0000_FFFE, 1'b0, 1'b0});
    vecs.push_back('{"and",       ALU_AND, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 16'h0000, 32'h0000_3030, 1'b0, 1'b0});
    vecs.push_back('{"or_fwd_b",  ALU_OR,  16'h0001, 16'h0005, 1'b0, 1'b1, 16'h0010, 32'h0000_0011, 1'b0, 1'b0});
    vecs.push_back('{"add_fwd_a", ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0100, 32'h0000_0101, 1'b0, 1'b0});
    vecs.push_back('{"sll15",     ALU_SLL, 16'h0001, 16'h000F, 1'b0, 1'b0, 16'h0000, 32'h0000_8000, 1'b0, 1'b0});
    vecs.push_back('{"srl4",      ALU_SRL, 16'h8000, 16'h0014, 1'b0, 1'b0, 16'h0000, 32'h0000_0800, 1'b0, 1'b0});
    vecs.push_back('{"rol1",      ALU_ROL, 16'h8001, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0000_0003, 1'b0, 1'b0});
    vecs.push_back('{"ror4",      ALU_ROR, 16'h8001, 16'h0004, 1'b0, 1'b0, 16'h0000, 32'h0000_1800, 1'b0, 1'b0});
    vecs.push_back('{"rol0",      ALU_ROL, 16'hA5C3, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0000_A5C3, 1'b0, 1'b0});
    vecs.push_back('{"mul_neg",   ALU_MUL, 16'hFFFE, 16'h0003, 1'b0, 1'b0, 16'h0000, 32'hFFFF_FFFA, 1'b0, 1'b0});
    vecs.push_back('{"mul_max",   ALU_MUL, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'h0000, 32'h3FFF_0001, 1'b0, 1'b0});
    vecs.push_back('{"div0",      ALU_DIV, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 32'h1234_FFFF, 1'b0, 1'b1});
    vecs.push_back('{"undef",     4'hF,    16'h1234, 16'h0001, 1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      logic rw, mc, r0;
      rw = 1'(i % 2);
      mc = 1'((i / 2) % 2);
      r0 = 1'((i / 4) % 2);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h1, vecs[i].h2, vecs[i].fwd,
            1'b0, 1'b0, rw, mc, r0, 16'hA500 + 16'(i), 16'h5A00 + 16'(i));
      @(negedge clk);
      check_busy({vecs[i].name, "_busy"}, 1'b0);
      @(posedge clk); #1;
      check_out(vecs[i].name, {vecs[i].exp_alu, vecs[i].exp_ovf, vecs[i].exp_div0, rw, mc, r0,
                               16'hA500 + 16'(i), 16'h5A00 + 16'(i)}, 1'b1);
    end

    // bubble loads a NOP; bubble together with DIV starts nothing
    drive(ALU_ADD, 16'h1, 16'h1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    check_out("bubble_nop", '0, 1'b0);
    drive(ALU_DIV, 16'd100, 16'd7, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
    @(negedge clk);
    check_busy("bubble_div_busy", 1'b0);
    @(posedge clk); #1;
    check_out("bubble_div_nop", '0, 1'b0);
    drive(ALU_ADD, 16'h2, 16'h3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444);
    @(negedge clk);
    check_busy("after_bubble_busy", 1'b0);
    @(posedge clk); #1;
    check_out("after_bubble", {32'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444}, 1'b1);

    // halt freezes the output register
    drive(ALU_ADD, 16'h1, 16'h2, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hCAFE, 16'hF00D);
    @(posedge clk); #1;
    check_out("pre_halt", {32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hCAFE, 16'hF00D}, 1'b1);
    for (int h = 0; h < 2; h++) begin
      drive(ALU_SUB, 16'h9, 16'h4, 1'b0, 1'b0, 16'h0, 1'(h), 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
      @(posedge clk); #1;
      check_out($sformatf("halt_hold%0d", h), {32'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hCAFE, 16'hF00D}, 1'b1);
    end
    halt_sys = 1'b0;

    div_seq("div_100_7", 16'd100, 16'd7, 1000, 0, {16'd2, 16'd14});
    div_seq("div_ffff_1", 16'hFFFF, 16'h0001, 1000, 0, ref_alu(ALU_DIV, 16'hFFFF, 16'h0001).alu);
    div_seq("div_3_10", 16'd3, 16'd10, 1000, 0, ref_alu(ALU_DIV, 16'd3, 16'd10).alu);
    div_seq("div_halt", 16'd50000, 16'd3, 5, 3, ref_alu(ALU_DIV, 16'd50000, 16'd3).alu);

    // reset while the divider is at count 5 aborts it
    drive(ALU_DIV, 16'd1000, 16'd3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7777, 16'h8888);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(ALU_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_out("rst_mid_div", '0, 1'b1);
    @(negedge clk);
    check_busy("rst_mid_div_busy", 1'b0);
    @(posedge clk); #1;
    div_seq("div_9_2", 16'd9, 16'd2, 1000, 0, {16'd1, 16'd4});

    // randomized run against the reference model
    model      = '0;
    model_pass = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b, fwd, ae, be, r1, ins;
      logic        h1, h2, bub, hlt, rw, mc, r0;
      op  = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      fwd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      h1  = ($urandom_range(0, 3) == 0);
      h2  = ($urandom_range(0, 3) == 0);
      bub = ($urandom_range(0, 7) == 0);
      hlt = (i != 0) && ($urandom_range(0, 7) == 0);
      rw  = 1'($urandom);  mc = 1'($urandom);  r0 = 1'($urandom);
      r1  = 16'($urandom); ins = 16'($urandom);
      ae  = h1 ? fwd : a;
      be  = h2 ? fwd : b;
`ifdef ITER_DIV_EN
      if (op == ALU_DIV && be != 16'h0) op = ALU_SUB;
`endif
      drive(op, a, b, h1, h2, fwd, bub, hlt, rw, mc, r0, r1, ins);
      @(negedge clk);
      check_busy($sformatf("rnd%0d_busy", i), 1'b0);
      @(posedge clk); #1;
      if (!hlt) begin
        if (bub) begin
          model      = '0;
          model_pass = 1'b0;
        end else begin
          model      = mk_exp(ref_alu(op, ae, be), rw, mc, r0, r1, ins);
          model_pass = 1'b1;
        end
      end
      check_out($sformatf("rnd%0d op=%0d a=%h b=%h bub=%b hlt=%b", i, op, ae, be, bub, hlt), model, model_pass);
    end
    halt_sys = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
